// File: rtl/pi_ctrl.sv
// pi_ctrl: priority-interrupt controller for the 7-level bus PI request lines.
// Holds PI-on, per-level enables, program requests and in-progress (hold) levels,
// arbitrates one new highest-priority level and reports status for RDPI.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   clken           clock enable; no state changes while low
//   crom            control ROM word (SPEC enable bit + SPEC select field)
//   dp[0:35]        datapath operand for LOADPI (WRPI)
//   bus_pi_req_in   device requests, [1] = level 1 (highest priority)
//   pi_int, pi_new  registered interrupt request and its level (0 when none)
//   pi_on           PI system enabled
//   pi_rdata        RDPI status word, combinational from the registers

`ifndef CROM_WIDTH
`define CROM_WIDTH 84
`endif

module pi_ctrl #(
  parameter int         cromWidth   = `CROM_WIDTH,
  parameter int         SPEC_EN_BIT = 20,
  parameter int         SPEC_SEL_LO = 21,
  parameter logic [3:0] SPEC_LOADPI = 4'd1,
  parameter logic [3:0] SPEC_PITAKE = 4'd2,
  parameter logic [3:0] SPEC_PIDISM = 4'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic [cromWidth-1:0] crom,
  input  logic [0:35]          dp,
  input  logic [1:7]           bus_pi_req_in,
  output logic                 pi_int,
  output logic [0:2]           pi_new,
  output logic                 pi_on,
  output logic [0:35]          pi_rdata
);

  logic [1:7] pi_en, sw_req, hold, req_sync;
  logic [1:7] pi_en_nxt, sw_req_nxt, hold_nxt;
  logic       pi_on_nxt;
  logic [1:7] sel, eff;
  logic [3:0] hmax;
  logic [2:0] cand;
  logic       cand_vld;
  logic [3:0] spec_sel;
  logic       spec_en;
  logic       load, take, dism;

  // Bits of the control word and datapath this block does not decode.
  logic unused_bits;
  assign unused_bits = ^{crom, dp[0:21]};

  assign spec_en  = crom[SPEC_EN_BIT];
  assign spec_sel = crom[SPEC_SEL_LO +: 4];
  assign load     = spec_en && (spec_sel == SPEC_LOADPI);
  assign take     = spec_en && (spec_sel == SPEC_PITAKE);
  assign dism     = spec_en && (spec_sel == SPEC_PIDISM);

  assign sel = dp[29:35];
  // Program requests bypass the level enables.
  assign eff = (req_sync & pi_en) | sw_req;

  // hmax: highest-priority level in progress (8 = nothing held).
  // Only levels strictly above it may interrupt.
  always_comb begin
    hmax     = 4'd8;
    cand     = 3'd0;
    cand_vld = 1'b0;
    for (int l = 7; l >= 1; l--) begin
      if (hold[l]) hmax = 4'(l);
    end
    for (int l = 7; l >= 1; l--) begin
      if (eff[l] && (l < int'(hmax))) begin
        cand     = 3'(l);
        cand_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pi_on_nxt  = pi_on;
    pi_en_nxt  = pi_en;
    sw_req_nxt = sw_req;
    hold_nxt   = hold;
    if (load) begin
      if (dp[23]) begin
        // Clear-system overrides every other bit in the word.
        pi_on_nxt  = 1'b0;
        pi_en_nxt  = '0;
        sw_req_nxt = '0;
        hold_nxt   = '0;
      end else begin
        if (dp[24])      sw_req_nxt = sw_req | sel;
        else if (dp[22]) sw_req_nxt = sw_req & ~sel;
        if (dp[26])      pi_en_nxt  = pi_en & ~sel;
        else if (dp[25]) pi_en_nxt  = pi_en | sel;
        if (dp[27])      pi_on_nxt  = 1'b0;
        else if (dp[28]) pi_on_nxt  = 1'b1;
      end
    end
    // A take is only meaningful while an interrupt is actually presented.
    if (take && pi_int) begin
      for (int l = 1; l <= 7; l++) begin
        if (pi_new == 3'(l)) begin
          hold_nxt[l]   = 1'b1;
          sw_req_nxt[l] = 1'b0;
        end
      end
    end
    // Dismiss retires the innermost (highest-priority) held level.
    if (dism) begin
      for (int l = 1; l <= 7; l++) begin
        if (hmax == 4'(l)) hold_nxt[l] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pi_on    <= 1'b0;
      pi_en    <= '0;
      sw_req   <= '0;
      hold     <= '0;
      req_sync <= '0;
      pi_int   <= 1'b0;
      pi_new   <= '0;
    end else if (clken) begin
      pi_on    <= pi_on_nxt;
      pi_en    <= pi_en_nxt;
      sw_req   <= sw_req_nxt;
      hold     <= hold_nxt;
      req_sync <= bus_pi_req_in;
      pi_int   <= pi_on && cand_vld;
      pi_new   <= cand;
    end
  end

  always_comb begin
    pi_rdata        = '0;
    pi_rdata[11:17] = sw_req;
    pi_rdata[21:27] = hold;
    pi_rdata[28]    = pi_on;
    pi_rdata[29:35] = pi_en;
  end

endmodule

// File: tb/tb_pi_ctrl.sv
// tb_pi_ctrl: directed bench for pi_ctrl.
// Drives WRPI loads, takes, dismisses and device requests as a linear sequence;
// outputs are sampled 1 time unit after the rising edge.

module tb_pi_ctrl;
  localparam int CW = 84;
  localparam logic [3:0] C_LOAD = 4'd1;
  localparam logic [3:0] C_TAKE = 4'd2;
  localparam logic [3:0] C_DISM = 4'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clken;
  logic [CW-1:0] crom;
  logic [0:35]   dp;
  logic [1:7]    bus_pi_req_in;
  logic          pi_int;
  logic [0:2]    pi_new;
  logic          pi_on;
  logic [0:35]   pi_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  pi_ctrl #(.cromWidth(CW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .crom(crom), .dp(dp),
    .bus_pi_req_in(bus_pi_req_in), .pi_int(pi_int), .pi_new(pi_new),
    .pi_on(pi_on), .pi_rdata(pi_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] spec(input logic [3:0] code);
    logic [CW-1:0] c;
    c = '0;
    c[20] = 1'b1;
    c[24:21] = code;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One LOADPI cycle: sel in dp[29:35], control bits in dp[22..28].
  task automatic load(input logic [6:0] s, input logic b22, input logic b23,
                      input logic b24, input logic b25, input logic b26,
                      input logic b27, input logic b28);
    logic [0:35] d;
    d = '0;
    d[22] = b22; d[23] = b23; d[24] = b24; d[25] = b25;
    d[26] = b26; d[27] = b27; d[28] = b28;
    d[29:35] = s;
    dp = d;
    crom = spec(C_LOAD);
    tick();
    crom = '0;
    dp = '0;
  endtask

  task automatic strobe(input logic [3:0] code);
    crom = spec(code);
    tick();
    crom = '0;
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; crom = '0; dp = '0; bus_pi_req_in = '0;
    tick(); tick();
    chk("rst_pi_int", 36'(pi_int), 36'd0);
    chk("rst_pi_new", 36'(pi_new), 36'd0);
    chk("rst_pi_on", 36'(pi_on), 36'd0);
    chk("rst_rdata", 36'(pi_rdata), 36'd0);
    rst = 1'b0;
    tick();

    // PI on, all levels enabled; device level 5.
    load(7'b1111111, 0, 0, 0, 1, 0, 0, 1);
    chk("on_rdata28", 36'(pi_rdata[28]), 36'd1);
    chk("on_en", 36'(pi_rdata[29:35]), 36'b1111111);
    bus_pi_req_in = 7'b0000100;
    tick();
    chk("l5_lat1", 36'(pi_int), 36'd0);
    tick();
    chk("l5_int", 36'(pi_int), 36'd1);
    chk("l5_new", 36'(pi_new), 36'd5);

    // Take level 5: held request must not re-interrupt.
    strobe(C_TAKE);
    chk("take5_hold", 36'(pi_rdata[21:27]), 36'b0000100);
    tick();
    chk("take5_noint", 36'(pi_int), 36'd0);

    // Level 3 pre-empts held level 5.
    bus_pi_req_in = 7'b0010100;
    tick(); tick();
    chk("l3_int", 36'(pi_int), 36'd1);
    chk("l3_new", 36'(pi_new), 36'd3);
    strobe(C_TAKE);
    chk("take3_hold", 36'(pi_rdata[21:27]), 36'b0010100);
    tick();
    chk("take3_noint", 36'(pi_int), 36'd0);
    bus_pi_req_in = 7'b0000100;
    tick();
    strobe(C_DISM);
    chk("dism3_hold", 36'(pi_rdata[21:27]), 36'b0000100);
    tick();
    chk("dism3_noint", 36'(pi_int), 36'd0);
    strobe(C_DISM);
    chk("dism5_hold", 36'(pi_rdata[21:27]), 36'd0);
    tick();
    chk("l5_repres_int", 36'(pi_int), 36'd1);
    chk("l5_repres_new", 36'(pi_new), 36'd5);
    bus_pi_req_in = '0;
    tick(); tick();
    chk("idle_noint", 36'(pi_int), 36'd0);

    // Level 2 disabled; then program request on level 2.
    load(7'b0100000, 0, 0, 0, 0, 1, 0, 0);
    bus_pi_req_in = 7'b0100000;
    tick(); tick(); tick();
    chk("l2_dis_noint", 36'(pi_int), 36'd0);
    chk("l2_dis_en", 36'(pi_rdata[29:35]), 36'b1011111);
    load(7'b0100000, 0, 0, 1, 0, 0, 0, 0);
    chk("sw2_req", 36'(pi_rdata[11:17]), 36'b0100000);
    tick();
    chk("sw2_int", 36'(pi_int), 36'd1);
    chk("sw2_new", 36'(pi_new), 36'd2);
    strobe(C_TAKE);
    chk("sw2_take_req", 36'(pi_rdata[12]), 36'd0);
    chk("sw2_take_hold", 36'(pi_rdata[22]), 36'd1);
    bus_pi_req_in = '0;
    strobe(C_DISM);
    tick(); tick();
    chk("sw2_done_noint", 36'(pi_int), 36'd0);

    // Simultaneous levels 4 and 7.
    bus_pi_req_in = 7'b0001001;
    tick(); tick();
    chk("l4l7_int", 36'(pi_int), 36'd1);
    chk("l4l7_new", 36'(pi_new), 36'd4);
    strobe(C_TAKE);
    tick(); tick();
    chk("l7_blocked", 36'(pi_int), 36'd0);
    bus_pi_req_in = 7'b0000001;
    tick();
    strobe(C_DISM);
    tick();
    chk("l7_int", 36'(pi_int), 36'd1);
    chk("l7_new", 36'(pi_new), 36'd7);
    bus_pi_req_in = '0;
    tick(); tick();

    // Clear-system overrides set bits in the same word.
    load(7'b1111111, 0, 1, 1, 1, 0, 0, 1);
    chk("clr_rdata", 36'(pi_rdata), 36'd0);
    chk("clr_pi_on", 36'(pi_on), 36'd0);
    tick();
    chk("clr_noint", 36'(pi_int), 36'd0);
    load(7'b0000000, 0, 0, 0, 0, 0, 0, 1);
    chk("on_only", 36'(pi_on), 36'd1);
    load(7'b0000000, 0, 0, 0, 0, 0, 1, 1);
    chk("on_off_conflict", 36'(pi_on), 36'd0);

    // Asynchronous reset with level 3 held and level 1 presented.
    load(7'b1111111, 0, 0, 0, 1, 0, 0, 1);
    bus_pi_req_in = 7'b0010000;
    tick(); tick();
    strobe(C_TAKE);
    bus_pi_req_in = 7'b1010000;
    tick(); tick();
    chk("pre_rst_hold", 36'(pi_rdata[21:27]), 36'b0010000);
    chk("pre_rst_int", 36'(pi_int), 36'd1);
    chk("pre_rst_new", 36'(pi_new), 36'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_int", 36'(pi_int), 36'd0);
    chk("arst_new", 36'(pi_new), 36'd0);
    chk("arst_on", 36'(pi_on), 36'd0);
    chk("arst_rdata", 36'(pi_rdata), 36'd0);
    tick();
    rst = 1'b0;
    bus_pi_req_in = '0;

    // clken low freezes take/dismiss.
    load(7'b1111111, 0, 0, 0, 1, 0, 0, 1);
    bus_pi_req_in = 7'b1000000;
    tick(); tick();
    chk("ce_int", 36'(pi_int), 36'd1);
    clken = 1'b0;
    crom = spec(C_TAKE);
    tick(); tick();
    crom = '0;
    chk("ce_take_hold", 36'(pi_rdata[21:27]), 36'd0);
    chk("ce_take_int", 36'(pi_int), 36'd1);
    clken = 1'b1;
    strobe(C_TAKE);
    chk("ce_take_on", 36'(pi_rdata[21:27]), 36'b1000000);
    clken = 1'b0;
    crom = spec(C_DISM);
    tick(); tick();
    crom = '0;
    chk("ce_dism_hold", 36'(pi_rdata[21:27]), 36'b1000000);
    clken = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
